// File: rtl/cache_fill_ctrl.sv
// Shared I/D-cache miss controller: arbitrates the two misses onto one memory
// port, streams the 8 block words into the data array, then writes the tag entry.
module cache_fill_ctrl #(
  parameter int WORDS  = 8,
  parameter int IDX_W  = 5,
  parameter int META_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_miss,
  input  logic [15:0]           icache_addr,
  input  logic                  dcache_miss,
  input  logic [15:0]           dcache_addr,
  input  logic                  mem_data_valid,
  output logic                  mem_en,
  output logic [15:0]           mem_addr,
  output logic                  fill_sel,
  output logic                  data_wr,
  output logic [$clog2(WORDS)-1:0] data_word,
  output logic                  meta_write,
  output logic [(1<<IDX_W)-1:0] meta_block_en,
  output logic [META_W-1:0]     meta_data,
  output logic                  fill_busy,
  output logic                  fill_done
);

  localparam int CNT_W   = $clog2(WORDS);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 16 - 4 - IDX_W;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, META, DONE} state_t;

  state_t           state, state_next;
  logic [15:0]      base;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             last_grant;
  logic [CNT_W-1:0] issue_cnt, ret_cnt;
  logic             issue_done, ret_done;

  // Tie goes to whichever cache was not served last; 1 selects D.
  logic       grant_any, grant_d;
  logic [15:0] grant_addr;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_any     = icache_miss | dcache_miss;
    grant_d       = dcache_miss & (~icache_miss | ~last_grant);
    grant_addr    = grant_d ? dcache_addr : icache_addr;
    state_next    = state;
    mem_en        = 1'b0;
    mem_addr      = '0;
    data_wr       = 1'b0;
    data_word     = '0;
    meta_write    = 1'b0;
    meta_block_en = '0;
    meta_data     = '0;
    fill_busy     = (state != IDLE);
    fill_done     = 1'b0;

    unique case (state)
      IDLE: if (grant_any) state_next = FILL;
      FILL: begin
        mem_en = ~issue_done;
        if (mem_en) mem_addr = base + {12'(issue_cnt), 1'b0};
        data_wr = mem_data_valid & ~ret_done;
        if (data_wr) begin
          data_word = ret_cnt;
          if (ret_cnt == LAST_WORD) state_next = META;
        end
      end
      META: begin
        meta_write    = 1'b1;
        meta_block_en = {{(ENTRIES-1){1'b0}}, 1'b1} << index;
        meta_data     = {1'b1, {(META_W-1-TAG_W){1'b0}}, tag};
        state_next    = DONE;
      end
      DONE: begin
        fill_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      index      <= '0;
      tag        <= '0;
      fill_sel   <= 1'b0;
      last_grant <= 1'b0;
      issue_cnt  <= '0;
      issue_done <= 1'b0;
      ret_cnt    <= '0;
      ret_done   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_any) begin
        base       <= grant_addr & 16'hFFF0;
        index      <= grant_addr[4 +: IDX_W];
        tag        <= grant_addr[15 -: TAG_W];
        fill_sel   <= grant_d;
        last_grant <= grant_d;
        issue_cnt  <= '0;
        issue_done <= 1'b0;
        ret_cnt    <= '0;
        ret_done   <= 1'b0;
      end
      // Counters saturate at the last word; the done flags stop further issues/writes.
      if (mem_en) begin
        if (issue_cnt == LAST_WORD) issue_done <= 1'b1;
        else                        issue_cnt  <= issue_cnt + 1'b1;
      end
      if (data_wr) begin
        if (ret_cnt == LAST_WORD) ret_done <= 1'b1;
        else                      ret_cnt  <= ret_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: a latency-programmable memory model drives
// returns and every cycle of each fill is compared against a hand-derived timeline.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_miss, dcache_miss, mem_data_valid;
  logic [15:0] icache_addr, dcache_addr;
  logic        mem_en, fill_sel, data_wr, meta_write, fill_busy, fill_done;
  logic [15:0] mem_addr;
  logic [2:0]  data_word;
  logic [31:0] meta_block_en;
  logic [9:0]  meta_data;

  int n_cmp = 0;
  int n_bad = 0;

  cache_fill_ctrl dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .mem_data_valid(mem_data_valid),
    .mem_en(mem_en), .mem_addr(mem_addr), .fill_sel(fill_sel),
    .data_wr(data_wr), .data_word(data_word),
    .meta_write(meta_write), .meta_block_en(meta_block_en), .meta_data(meta_data),
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_mem_en"}, 32'(mem_en), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_data_wr"}, 32'(data_wr), 0);
    check({tag, "_meta_write"}, 32'(meta_write), 0);
    check({tag, "_meta_block_en"}, meta_block_en, 0);
    check({tag, "_meta_data"}, 32'(meta_data), 0);
    check({tag, "_fill_busy"}, 32'(fill_busy), 0);
    check({tag, "_fill_done"}, 32'(fill_done), 0);
  endtask

  // Entry: just after a posedge, in the IDLE cycle where the miss is visible (cycle 0).
  // Exit: just after the posedge ending the fill_done cycle (next IDLE cycle).
  task automatic do_fill(input string tag, input logic sel, input logic [15:0] addr,
                         input int lat, input bit extra, input bit hold);
    bit   pending[64];
    int   last_ret, word;
    logic [15:0] base;
    logic [4:0]  idx;
    logic [6:0]  tg;
    base     = addr & 16'hFFF0;
    idx      = addr[8:4];
    tg       = addr[15:9];
    last_ret = 8 + lat;
    word     = 0;
    foreach (pending[i]) pending[i] = 1'b0;
    if (extra) pending[last_ret + 1] = 1'b1;  // ninth return lands in META
    mem_data_valid = 1'b0;
    for (int c = 0; c <= last_ret + 2; c++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(fill_busy), 32'(c >= 1));
      check({tag, "_mem_en"}, 32'(mem_en), 32'(c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) begin
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'(base + 16'(2 * (c - 1))));
        pending[c + lat] = 1'b1;
      end
      if (c >= 1) check({tag, "_fill_sel"}, 32'(fill_sel), 32'(sel));
      check({tag, "_data_wr"}, 32'(data_wr), 32'(pending[c] && c <= last_ret));
      if (pending[c] && c <= last_ret) begin
        check({tag, "_data_word"}, 32'(data_word), 32'(word));
        word++;
      end
      check({tag, "_meta_write"}, 32'(meta_write), 32'(c == last_ret + 1));
      if (c == last_ret + 1) begin
        check({tag, "_meta_block_en"}, meta_block_en, 32'(1) << idx);
        check({tag, "_meta_data"}, 32'(meta_data), 32'({1'b1, 2'b00, tg}));
      end else begin
        check({tag, "_meta_block_en_zero"}, meta_block_en, 0);
      end
      check({tag, "_fill_done"}, 32'(fill_done), 32'(c == last_ret + 2));
      @(posedge clk);
      #1;
      mem_data_valid = pending[c + 1];
    end
    check({tag, "_word_count"}, 32'(word), 8);
    mem_data_valid = 1'b0;
    if (!hold) begin
      if (sel) dcache_miss = 1'b0;
      else     icache_miss = 1'b0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    icache_miss = 1'b0; dcache_miss = 1'b0; mem_data_valid = 1'b0;
    icache_addr = '0;   dcache_addr = '0;
    repeat (2) next_cycle();
    @(negedge clk);
    check_idle_zero("reset");
    check("reset_fill_sel", 32'(fill_sel), 0);
    next_cycle();
    rst = 1'b0;

    // First tie after reset goes to D, then I follows; a second tie goes to D again.
    icache_miss = 1'b1; icache_addr = 16'h2468;
    dcache_miss = 1'b1; dcache_addr = 16'h1357;
    do_fill("tie1_d", 1'b1, 16'h1357, 4, 0, 0);
    do_fill("tie1_i", 1'b0, 16'h2468, 4, 0, 0);
    icache_miss = 1'b1; dcache_miss = 1'b1;
    do_fill("tie2_d", 1'b1, 16'h1357, 2, 0, 0);
    do_fill("tie2_i", 1'b0, 16'h2468, 3, 0, 0);

    // Single I-miss at 1234: index 3, tag 09, meta_data 10'b1000001001.
    icache_miss = 1'b1; icache_addr = 16'h1234;
    do_fill("imiss_1234", 1'b0, 16'h1234, 4, 0, 0);

    // D-miss at FFFE: base FFF0, index 31, tag 7F, meta_data 10'h27F.
    dcache_miss = 1'b1; dcache_addr = 16'hFFFE;
    do_fill("dmiss_lat1", 1'b1, 16'hFFFE, 1, 0, 0);
    dcache_miss = 1'b1;
    do_fill("dmiss_lat7_extra", 1'b1, 16'hFFFE, 7, 1, 0);

    // Spurious return while idle.
    mem_data_valid = 1'b1;
    @(negedge clk);
    check_idle_zero("spurious_idle");
    next_cycle();
    mem_data_valid = 1'b0;
    @(negedge clk);
    check("spurious_idle_after_busy", 32'(fill_busy), 0);

    // Miss held one cycle past fill_done restarts a full fill.
    next_cycle();
    icache_miss = 1'b1; icache_addr = 16'h0ABC;
    do_fill("hold_first", 1'b0, 16'h0ABC, 4, 0, 1);
    do_fill("hold_second", 1'b0, 16'h0ABC, 4, 0, 0);

    // Reset during cycle 6 of a fill, then a fresh fill after it.
    icache_miss = 1'b1; icache_addr = 16'h5550;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      mem_data_valid = (c + 1 >= 5);
    end
    rst = 1'b1;
    icache_miss = 1'b0;
    next_cycle();
    rst = 1'b0;
    mem_data_valid = 1'b0;
    @(negedge clk);
    check_idle_zero("after_midfill_rst");
    check("after_midfill_rst_fill_sel", 32'(fill_sel), 0);
    next_cycle();
    dcache_miss = 1'b1; dcache_addr = 16'h8010;
    do_fill("post_rst", 1'b1, 16'h8010, 4, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
